// File: rtl/rvv_pkg.sv
// rtl/rvv_pkg.sv - shared VRF geometry, types and address decode helpers
package rvv_pkg;

  localparam int unsigned NrBank         = 4;
  localparam int unsigned NrOpQueue      = 4;
  localparam int unsigned NrWriteBackVFU = 2;
  localparam int unsigned VrfAddrWidth   = 8;
  localparam int unsigned VrfDataWidth   = 32;
  localparam int unsigned LogNrBank      = $clog2(NrBank);

  typedef logic [LogNrBank-1:0]              bank_id_t;
  typedef logic [VrfAddrWidth-LogNrBank-1:0] bank_addr_t;
  typedef logic [VrfAddrWidth-1:0]           vrf_addr_t;
  typedef logic [VrfDataWidth-1:0]           vrf_data_t;
  typedef logic [VrfDataWidth/8-1:0]         vrf_strb_t;

  // Low address bits interleave consecutive registers across banks.
  function automatic bank_id_t addr_bank(vrf_addr_t addr);
    return addr[LogNrBank-1:0];
  endfunction

  function automatic bank_addr_t addr_row(vrf_addr_t addr);
    return bank_addr_t'(addr >> LogNrBank);
  endfunction

endpackage

// File: rtl/vrf_bank_arb.sv
// rtl/vrf_bank_arb.sv - one bank: write/read round-robin, starve counter, class select
module vrf_bank_arb #(
  parameter int unsigned NrRd        = 4,
  parameter int unsigned NrWr        = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NrRd-1:0] rd_req_i,
  input  logic [NrWr-1:0] wr_req_i,
  output logic [NrRd-1:0] rd_gnt_o,
  output logic [NrWr-1:0] wr_gnt_o
);

  localparam int unsigned RdPtrW = (NrRd > 1) ? $clog2(NrRd) : 1;
  localparam int unsigned WrPtrW = (NrWr > 1) ? $clog2(NrWr) : 1;
  localparam int unsigned CntW   = $clog2(StarveLimit + 1);

  logic [RdPtrW-1:0] rd_ptr_q, rd_ptr_d, rd_next, rd_sel;
  logic [WrPtrW-1:0] wr_ptr_q, wr_ptr_d, wr_next, wr_sel;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [NrRd-1:0]   rd_pick;
  logic [NrWr-1:0]   wr_pick;
  int unsigned       rd_idx, wr_idx;
  logic              rd_any, wr_any, rd_win, wr_win;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    rd_pick = '0;
    rd_next = rd_ptr_q;
    rd_idx  = 0;
    rd_sel  = '0;
    for (int unsigned off = 0; off < NrRd; off++) begin
      rd_idx = 32'(rd_ptr_q) + off;
      if (rd_idx >= NrRd) rd_idx = rd_idx - NrRd;
      rd_sel = RdPtrW'(rd_idx);
      if (rd_req_i[rd_sel] && rd_pick == '0) begin
        rd_pick[rd_sel] = 1'b1;
        rd_next = (rd_idx + 1 == NrRd) ? '0 : RdPtrW'(rd_idx + 1);
      end
    end
  end

  always_comb begin
    wr_pick = '0;
    wr_next = wr_ptr_q;
    wr_idx  = 0;
    wr_sel  = '0;
    for (int unsigned off = 0; off < NrWr; off++) begin
      wr_idx = 32'(wr_ptr_q) + off;
      if (wr_idx >= NrWr) wr_idx = wr_idx - NrWr;
      wr_sel = WrPtrW'(wr_idx);
      if (wr_req_i[wr_sel] && wr_pick == '0) begin
        wr_pick[wr_sel] = 1'b1;
        wr_next = (wr_idx + 1 == NrWr) ? '0 : WrPtrW'(wr_idx + 1);
      end
    end
  end

  assign rd_any   = |rd_req_i;
  assign wr_any   = |wr_req_i;
  assign wr_win   = wr_any && !(rd_any && starve_q == CntW'(StarveLimit));
  assign rd_win   = rd_any && !wr_win;
  assign rd_gnt_o = rd_win ? rd_pick : '0;
  assign wr_gnt_o = wr_win ? wr_pick : '0;

  always_comb begin
    rd_ptr_d = rd_win ? rd_next : rd_ptr_q;
    wr_ptr_d = wr_win ? wr_next : wr_ptr_q;
    starve_d = starve_q;
    if (!rd_any || rd_win) begin
      starve_d = '0;
    end else if (starve_q != CntW'(StarveLimit)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      starve_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/vrf_bank_scheduler.sv
// rtl/vrf_bank_scheduler.sv - per-bank VRF access scheduler with 1-cycle read return
module vrf_bank_scheduler
  import rvv_pkg::*;
#(
  parameter int unsigned NrRd        = NrOpQueue,
  parameter int unsigned NrWr        = NrWriteBackVFU,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic       [NrRd-1:0]    rd_req_i,
  input  vrf_addr_t  [NrRd-1:0]    rd_addr_i,
  output logic       [NrRd-1:0]    rd_gnt_o,
  input  logic       [NrWr-1:0]    wr_req_i,
  input  vrf_addr_t  [NrWr-1:0]    wr_addr_i,
  input  vrf_data_t  [NrWr-1:0]    wr_data_i,
  input  vrf_strb_t  [NrWr-1:0]    wr_strb_i,
  output logic       [NrWr-1:0]    wr_gnt_o,
  output logic       [NrBank-1:0]  bank_req_o,
  output logic       [NrBank-1:0]  bank_wen_o,
  output bank_addr_t [NrBank-1:0]  bank_addr_o,
  output vrf_data_t  [NrBank-1:0]  bank_wdata_o,
  output vrf_strb_t  [NrBank-1:0]  bank_wstrb_o,
  input  vrf_data_t  [NrBank-1:0]  bank_rdata_i,
  output logic       [NrRd-1:0]    rd_valid_o,
  output vrf_data_t  [NrRd-1:0]    rd_data_o
);

  logic [NrBank-1:0][NrRd-1:0] bank_rd_req, bank_rd_gnt;
  logic [NrBank-1:0][NrWr-1:0] bank_wr_req, bank_wr_gnt;
  logic     [NrRd-1:0] rd_valid_q;
  bank_id_t [NrRd-1:0] rd_bank_q, rd_bank_d;

  always_comb begin
    bank_rd_req = '0;
    bank_wr_req = '0;
    for (int q = 0; q < NrRd; q++) begin
      bank_rd_req[addr_bank(rd_addr_i[q])][q] = rd_req_i[q];
    end
    for (int w = 0; w < NrWr; w++) begin
      bank_wr_req[addr_bank(wr_addr_i[w])][w] = wr_req_i[w];
    end
  end

  for (genvar b = 0; b < NrBank; b++) begin : gen_bank
    vrf_bank_arb #(
      .NrRd        (NrRd),
      .NrWr        (NrWr),
      .StarveLimit (StarveLimit)
    ) u_arb (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .rd_req_i (bank_rd_req[b]),
      .wr_req_i (bank_wr_req[b]),
      .rd_gnt_o (bank_rd_gnt[b]),
      .wr_gnt_o (bank_wr_gnt[b])
    );
  end

  // Each requester decodes to exactly one bank, so OR-ing per-bank grants is safe.
  always_comb begin
    rd_gnt_o     = '0;
    wr_gnt_o     = '0;
    bank_req_o   = '0;
    bank_wen_o   = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_wstrb_o = '0;
    for (int b = 0; b < NrBank; b++) begin
      rd_gnt_o = rd_gnt_o | bank_rd_gnt[b];
      wr_gnt_o = wr_gnt_o | bank_wr_gnt[b];
      for (int q = 0; q < NrRd; q++) begin
        if (bank_rd_gnt[b][q]) begin
          bank_req_o[b]  = 1'b1;
          bank_addr_o[b] = addr_row(rd_addr_i[q]);
        end
      end
      for (int w = 0; w < NrWr; w++) begin
        if (bank_wr_gnt[b][w]) begin
          bank_req_o[b]   = 1'b1;
          bank_wen_o[b]   = 1'b1;
          bank_addr_o[b]  = addr_row(wr_addr_i[w]);
          bank_wdata_o[b] = wr_data_i[w];
          bank_wstrb_o[b] = wr_strb_i[w];
        end
      end
    end
  end

  always_comb begin
    rd_bank_d = rd_bank_q;
    for (int q = 0; q < NrRd; q++) begin
      if (rd_gnt_o[q]) rd_bank_d[q] = addr_bank(rd_addr_i[q]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= '0;
      rd_bank_q  <= '0;
    end else begin
      rd_valid_q <= rd_gnt_o;
      rd_bank_q  <= rd_bank_d;
    end
  end

  assign rd_valid_o = rd_valid_q;

  always_comb begin
    rd_data_o = '0;
    for (int q = 0; q < NrRd; q++) begin
      rd_data_o[q] = bank_rdata_i[rd_bank_q[q]];
    end
  end

endmodule

// File: tb/tb_vrf_bank_scheduler.sv
// tb/tb_vrf_bank_scheduler.sv - scoreboard bench for vrf_bank_scheduler
module tb_vrf_bank_scheduler;
  import rvv_pkg::*;

  localparam int NR = 4;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic       [NR-1:0]     rd_req;
  vrf_addr_t  [NR-1:0]     rd_addr;
  logic       [NR-1:0]     rd_gnt;
  logic       [NW-1:0]     wr_req;
  vrf_addr_t  [NW-1:0]     wr_addr;
  vrf_data_t  [NW-1:0]     wr_data;
  vrf_strb_t  [NW-1:0]     wr_strb;
  logic       [NW-1:0]     wr_gnt;
  logic       [NrBank-1:0] bank_req, bank_wen;
  bank_addr_t [NrBank-1:0] bank_addr;
  vrf_data_t  [NrBank-1:0] bank_wdata, bank_rdata;
  vrf_strb_t  [NrBank-1:0] bank_wstrb;
  logic       [NR-1:0]     rd_valid;
  vrf_data_t  [NR-1:0]     rd_data;

  typedef struct {
    int        q;
    int        due;
    vrf_data_t data;
  } ret_t;

  ret_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  vrf_bank_scheduler #(.NrRd(NR), .NrWr(NW), .StarveLimit(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rd_req_i     (rd_req),
    .rd_addr_i    (rd_addr),
    .rd_gnt_o     (rd_gnt),
    .wr_req_i     (wr_req),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_strb_i    (wr_strb),
    .wr_gnt_o     (wr_gnt),
    .bank_req_o   (bank_req),
    .bank_wen_o   (bank_wen),
    .bank_addr_o  (bank_addr),
    .bank_wdata_o (bank_wdata),
    .bank_wstrb_o (bank_wstrb),
    .bank_rdata_i (bank_rdata),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data)
  );

  always #5 clk = ~clk;

  function automatic vrf_data_t mk_data(int b, int row);
    return 32'hD000_0000 | (32'(b) << 16) | 32'(row);
  endfunction

  // Bank memory: one-cycle read latency, content derived from bank and row.
  always @(posedge clk) begin
    for (int b = 0; b < NrBank; b++) begin
      bank_rdata[b] <= (bank_req[b] && !bank_wen[b]) ? mk_data(b, int'(bank_addr[b])) : 32'hDEAD_BEEF;
    end
  end

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_returns();
    ret_t e;
    int   n;
    n = 0;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check_eq($sformatf("rd_valid[%0d]", e.q), 64'(rd_valid[e.q]), 64'd1);
      check_eq($sformatf("rd_data[%0d]", e.q), 64'(rd_data[e.q]), 64'(e.data));
      n++;
    end
    check_eq("n_valid", 64'($countones(rd_valid)), 64'(n));
  endtask

  task automatic run_cycle(string tag, logic [NR-1:0] exp_rd, logic [NW-1:0] exp_wr);
    int a;
    #1;
    check_eq({tag, ".rd_gnt"}, 64'(rd_gnt), 64'(exp_rd));
    check_eq({tag, ".wr_gnt"}, 64'(wr_gnt), 64'(exp_wr));
    for (int q = 0; q < NR; q++) begin
      if (exp_rd[q]) begin
        a = int'(rd_addr[q]);
        sb.push_back('{q: q, due: cyc + 1, data: mk_data(a % int'(NrBank), a / int'(NrBank))});
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_returns();
  endtask

  task automatic idle_in();
    rd_req  = '0;
    rd_addr = '0;
    wr_req  = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_strb = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    #3;
    check_eq("rst.rd_valid", 64'(rd_valid), 64'd0);
    check_eq("rst.bank_req", 64'(bank_req), 64'd0);
    check_eq("rst.rd_gnt", 64'(rd_gnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two reads to different banks in the same cycle.
    rd_req = 4'b0011; rd_addr[0] = 8'h05; rd_addr[1] = 8'h06;
    #1;
    check_eq("s1.bank_req", 64'(bank_req), 64'b0110);
    check_eq("s1.addr1", 64'(bank_addr[1]), 64'd1);
    check_eq("s1.addr2", 64'(bank_addr[2]), 64'd1);
    check_eq("s1.wen", 64'(bank_wen), 64'd0);
    run_cycle("s1", 4'b0011, 2'b00);

    // Read round-robin on bank 0.
    rd_req = 4'b0011; rd_addr[0] = 8'h00; rd_addr[1] = 8'h04;
    run_cycle("s2a", 4'b0001, 2'b00);
    run_cycle("s2b", 4'b0010, 2'b00);
    run_cycle("s2c", 4'b0001, 2'b00);
    run_cycle("s2d", 4'b0010, 2'b00);

    // Write beats read on bank 2; payload is the write's.
    idle_in();
    wr_req = 2'b10; wr_addr[1] = 8'h02; wr_data[1] = 32'hCAFE_F00D; wr_strb[1] = 4'h5;
    rd_req = 4'b0010; rd_addr[1] = 8'h06;
    #1;
    check_eq("s3.req2", 64'(bank_req[2]), 64'd1);
    check_eq("s3.wen2", 64'(bank_wen[2]), 64'd1);
    check_eq("s3.wdata2", 64'(bank_wdata[2]), 64'hCAFE_F00D);
    check_eq("s3.wstrb2", 64'(bank_wstrb[2]), 64'h5);
    check_eq("s3.addr2", 64'(bank_addr[2]), 64'd0);
    check_eq("s3.idle_wdata0", 64'(bank_wdata[0]), 64'd0);
    check_eq("s3.idle_req0", 64'(bank_req[0]), 64'd0);
    run_cycle("s3", 4'b0000, 2'b10);
    wr_req = 2'b00;
    run_cycle("s3r", 4'b0010, 2'b00);

    // Write round-robin on bank 1.
    idle_in();
    wr_req = 2'b11; wr_addr[0] = 8'h01; wr_addr[1] = 8'h05;
    run_cycle("s4a", 4'b0000, 2'b01);
    run_cycle("s4b", 4'b0000, 2'b10);
    run_cycle("s4c", 4'b0000, 2'b01);

    // Starvation limit on bank 3.
    idle_in();
    wr_req = 2'b01; wr_addr[0] = 8'h03; rd_req = 4'b0001; rd_addr[0] = 8'h07;
    for (int i = 0; i < 4; i++) run_cycle($sformatf("s5w%0d", i), 4'b0000, 2'b01);
    run_cycle("s5r", 4'b0001, 2'b00);
    rd_req = 4'b0000;
    run_cycle("s5resume", 4'b0000, 2'b01);

    // Build non-zero pointer and counter state, then reset.
    idle_in();
    rd_req = 4'b0011; rd_addr[0] = 8'h00; rd_addr[1] = 8'h04;
    run_cycle("s6ptr", 4'b0001, 2'b00);
    idle_in();
    wr_req = 2'b01; wr_addr[0] = 8'h03; rd_req = 4'b0100; rd_addr[2] = 8'h0B;
    run_cycle("s6st0", 4'b0000, 2'b01);
    run_cycle("s6st1", 4'b0000, 2'b01);
    idle_in();
    rd_req = 4'b0100; rd_addr[2] = 8'h09;
    run_cycle("s6q2", 4'b0100, 2'b00);
    rd_req = 4'b1000; rd_addr[3] = 8'h0A;
    #1;
    check_eq("s6.gnt_q3", 64'(rd_gnt), 64'b1000);
    check_eq("s6.valid_pre", 64'(rd_valid), 64'b0100);
    rst_n = 1'b0;
    #1;
    check_eq("s6.valid_now", 64'(rd_valid), 64'd0);
    idle_in();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check_eq("s6.valid_held", 64'(rd_valid), 64'd0);
    rst_n = 1'b1;
    run_cycle("s6idle0", 4'b0000, 2'b00);
    run_cycle("s6idle1", 4'b0000, 2'b00);

    rd_req = 4'b0011; rd_addr[0] = 8'h00; rd_addr[1] = 8'h04;
    run_cycle("s6ptr0", 4'b0001, 2'b00);
    idle_in();
    wr_req = 2'b01; wr_addr[0] = 8'h03; rd_req = 4'b0100; rd_addr[2] = 8'h0B;
    for (int i = 0; i < 4; i++) run_cycle($sformatf("s6cw%0d", i), 4'b0000, 2'b01);
    run_cycle("s6cr", 4'b0100, 2'b00);
    idle_in();
    run_cycle("s6end", 4'b0000, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vrf_bank_scheduler.md
VRF_BANK_SCHEDULER -- requirements
Module: vrf_bank_scheduler

Interface
REQ-001 Parameter: NrRd, default NrOpQueue, number of read requesters (operand queues).
REQ-002 Parameter: NrWr, default NrWriteBackVFU, number of write requesters (VFU writeback ports).
REQ-003 Parameter: StarveLimit, default 4, maximum number of consecutive cycles a pending read may lose its bank to writes.
REQ-004 clk_i  in  1  clock; single clock domain; all state updates on rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 rd_req_i  in  NrRd  read request, one bit per operand queue.
REQ-007 rd_addr_i  in  NrRd x vrf_addr_t  read VRF address per requester.
REQ-008 rd_gnt_o  out  NrRd  read granted this cycle.
REQ-009 wr_req_i  in  NrWr  write request (already commit-qualified by caller).
REQ-010 wr_addr_i / wr_data_i / wr_strb_i  in  NrWr x vrf_addr_t / vrf_data_t / vrf_strb_t  write address, data and byte strobe.
REQ-011 wr_gnt_o  out  NrWr  write granted this cycle.
REQ-012 bank_req_o / bank_wen_o  out  NrBank / NrBank  bank access enable and write enable.
REQ-013 bank_addr_o / bank_wdata_o / bank_wstrb_o  out  NrBank x bank_addr_t / vrf_data_t / vrf_strb_t  per-bank payload.
REQ-014 bank_rdata_i  in  NrBank x vrf_data_t  bank read data; valid one cycle after bank_req_o with wen=0.
REQ-015 rd_valid_o  out  NrRd  returned operand valid.
REQ-016 rd_data_o  out  NrRd x vrf_data_t  returned operand.

Function
REQ-017 Address decode: bank = addr[log2(NrBank)-1:0]; bank row = addr >> log2(NrBank), truncated to bank_addr_t.
REQ-018 Each bank is arbitrated independently each cycle and grants at most one requester; requesters targeting different banks are all granted in the same cycle.
REQ-019 Default priority: any pending write to a bank beats any pending read to that bank.
REQ-020 Among competing writes, a per-bank write round-robin pointer selects the winner; among competing reads, a per-bank read round-robin pointer selects the winner.
REQ-021 On a grant, the corresponding pointer moves to (winner index + 1) mod count; it does not move when that class is not granted.
REQ-022 Per-bank starve counter: increments (saturating at StarveLimit) when the bank has a pending read and a write wins; clears on a read grant or when no read is pending.
REQ-023 When the starve counter equals StarveLimit and a read is pending, the read class wins that cycle and all writes to that bank are stalled (no wr_gnt).
REQ-024 Grants are combinational from the same-cycle requests; bank_* outputs carry the winner's payload; bank_wen_o=1 only for a write winner; idle banks drive req=0 with zero payload.
REQ-025 Read return latency is exactly 1 cycle: rd_valid_o[q] equals rd_gnt_o[q] registered, and rd_data_o[q] = bank_rdata_i[registered bank of q].
REQ-026 Back-to-back grants to the same requester on consecutive cycles produce consecutive rd_valid_o pulses with no bubble.
REQ-027 A request that is not granted shall be held by its requester; the block stores no request state.
REQ-028 No requester is ever granted in two banks; a write and a read to the same bank in the same cycle never both complete.

Reset
REQ-029 Asynchronous reset: all RR pointers=0, starve counters=0, rd_valid_o=0 immediately; registered bank selection is don't-care.
REQ-030 Reset asserted mid-access discards any in-flight read return; no rd_valid_o is produced for it after reset release.

Structure
REQ-031 NrBank, bank_id_t, bank_addr_t, vrf_addr_t, vrf_data_t and vrf_strb_t are used from rvv_pkg; StarveLimit remains a local parameter.
REQ-032 A single per-bank sub-module, vrf_bank_arb (write RR, read RR, starve counter, class select), is instantiated NrBank times.

Verification
REQ-033 Two reads, NrBank=4, addr 0x05 and 0x06 (banks 1 and 2), same cycle -> both granted; both rd_valid_o next cycle with the respective bank data.
REQ-034 Reads q0 and q1 both to bank 0, held for 4 cycles -> grants alternate q0,q1,q0,q1.
REQ-035 Continuous write to bank 3 plus a held read to bank 3, StarveLimit=4 -> write granted 4 cycles, read granted on cycle 5, write then resumes.
REQ-036 Write and read to bank 2 in the same cycle, counter 0 -> wr_gnt=1, rd_gnt=0, bank_wen_o[2]=1 with the write's data and strobe.
REQ-037 rst_ni pulled low one cycle after a read grant -> rd_valid_o=0 immediately and stays 0 after reset release; pointers and counters read 0.
